control_multiciclo: RTL and testbench
=====================================

# control_multiciclo

Multi-cycle MIPS control FSM that sequences the shared datapath through a single ALU, a unified instruction/data memory, an IR and the register file. It replaces per-instruction combinational decode with one Moore state machine. The machine steps through FETCH → DECODE → execute → memory → write-back and drives every datapath enable and mux select. It supports R-type, lw, sw, beq, addi and j, and flags illegal opcodes.

## Interface
Parameters:
- none

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- op_code  in  6  instruction bits [31:26] from the IR; valid in DECODE
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (ANDed in datapath)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALU out
- mem_read_enable  out  1  memory read strobe
- mem_write_enable  out  1  memory write strobe
- ir_write  out  1  IR load
- mem_to_reg  out  1  write-back data select: 0 = ALU, 1 = MDR
- reg_dst  out  1  destination select: 0 = rt, 1 = rd
- reg_write  out  1  register file write
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- alu_op_code  out  3  000 = add, 001 = sub, 010 = funct-decoded
- pc_source  out  2  00 = ALU result, 01 = ALU out reg, 10 = jump target
- state  out  4  current state, for debug
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB, ILLEGAL.
- Outputs are decoded from the state only (Moore). Every output not listed for a state is 0; outputs are never x.
- Opcode latching: op_code is captured into an internal register during DECODE. Later states use only this latched copy.
- FETCH: mem_read_enable = 1, i_or_d = 0, alu_src_b = 01, alu_op_code = 000. In the completing cycle, ir_write = 1 and pc_write = 1. Next state: DECODE.
- DECODE: alu_src_b = 11, alu_op_code = 000. Next state by opcode:
  - 100011 or 101011 → MEM_ADDR
  - 000000 → EXEC_R
  - 000100 → BRANCH
  - 001000 → ADDI_EXEC
  - 000010 → JUMP
  - anything else → ILLEGAL
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10. Next state: MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read_enable = 1, i_or_d = 1. Next state: MEM_WB on completion.
- MEM_WB: mem_to_reg = 1, reg_write = 1. Next state: FETCH.
- MEM_WRITE: mem_write_enable = 1, i_or_d = 1. Next state: FETCH on completion.
- EXEC_R: alu_src_a = 1, alu_src_b = 00, alu_op_code = 010. Next state: R_WB.
- R_WB: reg_dst = 1, reg_write = 1. Next state: FETCH.
- BRANCH: alu_src_a = 1, alu_op_code = 001, pc_write_cond = 1, pc_source = 01. Next state: FETCH.
- JUMP: pc_write = 1, pc_source = 10. Next state: FETCH.
- ADDI_EXEC: alu_src_a = 1, alu_src_b = 10. Next state: ADDI_WB.
- ADDI_WB: reg_write = 1. Next state: FETCH.
- ILLEGAL: illegal_op = 1, no writes. Next state: FETCH.
- instr_done pulses in MEM_WB, the completing cycle of MEM_WRITE, R_WB, BRANCH, JUMP, ADDI_WB and ILLEGAL.

## Timing
- Reset: when rst is high at a clock edge, the next state is FETCH and the latched opcode becomes 0. This applies at any point, including mid-instruction.
- While rst is high, all strobes (pc_write, pc_write_cond, ir_write, mem_read_enable, mem_write_enable, reg_write) are forced to 0. After reset is released, the first cycle is FETCH.
- Cycles per instruction with zero memory wait:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - illegal: 3
- Memory wait:
  - FETCH, MEM_READ and MEM_WRITE hold their state and strobes while mem_ready = 0.
  - Each low cycle adds exactly one cycle to the instruction.
  - In a wait cycle of FETCH, ir_write and pc_write stay 0.
- op_code only needs to be valid in DECODE; changes to it in other states are ignored.

## Configuration
- CTRL_MEM_WAIT_EN defined: mem_ready gates FETCH, MEM_READ and MEM_WRITE as described under Timing.
- CTRL_MEM_WAIT_EN undefined: mem_ready is ignored and every memory state lasts exactly one cycle.

## Structure
- Shared package mips_ctrl_pkg holds:
  - the state encoding (4-bit localparams)
  - the opcode constants
  - the alu_op_code, alu_src_b and pc_source encodings
- One sub-module, ctrl_next_state, holds the combinational next-state logic. The top level holds the state register, the opcode latch and the output decode.

## Test plan
- R-type (000000), mem_ready = 1 → states FETCH, DECODE, EXEC_R, R_WB. alu_op_code = 010 in EXEC_R. reg_write = 1 and reg_dst = 1 only in cycle 4. instr_done in cycle 4.
- lw (100011) with mem_ready low 2 cycles in MEM_READ → 7 cycles total. mem_read_enable and i_or_d = 1 for 3 cycles. mem_to_reg = 1 and reg_write = 1 for 1 cycle.
- sw (101011), then beq (000100) → sw: mem_write_enable = 1 for exactly 1 cycle, 4 cycles total. beq: pc_write_cond = 1, pc_source = 01 and alu_op_code = 001 in cycle 3.
- Opcode 111111 → illegal_op pulses in cycle 3. No write strobe is asserted. The next cycle is FETCH.
- rst asserted in MEM_READ → the following cycle is FETCH and the outputs show no write strobe. The latched opcode reads 0.
- Build without CTRL_MEM_WAIT_EN and hold mem_ready = 0 → lw still completes in 5 cycles and j in 3 cycles, with pc_write = 1 and pc_source = 10 in JUMP.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// Module   : mips_ctrl_pkg
// Purpose  : Shared encodings for the multi-cycle MIPS control FSM.
//            Covers the states, opcodes, ALU op, ALU B source and PC source.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_FETCH     = 4'd0;
    localparam logic [STATE_W-1:0] ST_DECODE    = 4'd1;
    localparam logic [STATE_W-1:0] ST_MEM_ADDR  = 4'd2;
    localparam logic [STATE_W-1:0] ST_MEM_READ  = 4'd3;
    localparam logic [STATE_W-1:0] ST_MEM_WB    = 4'd4;
    localparam logic [STATE_W-1:0] ST_MEM_WRITE = 4'd5;
    localparam logic [STATE_W-1:0] ST_EXEC_R    = 4'd6;
    localparam logic [STATE_W-1:0] ST_R_WB      = 4'd7;
    localparam logic [STATE_W-1:0] ST_BRANCH    = 4'd8;
    localparam logic [STATE_W-1:0] ST_JUMP      = 4'd9;
    localparam logic [STATE_W-1:0] ST_ADDI_EXEC = 4'd10;
    localparam logic [STATE_W-1:0] ST_ADDI_WB   = 4'd11;
    localparam logic [STATE_W-1:0] ST_ILLEGAL   = 4'd12;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = ST_FETCH,
        S_DECODE    = ST_DECODE,
        S_MEM_ADDR  = ST_MEM_ADDR,
        S_MEM_READ  = ST_MEM_READ,
        S_MEM_WB    = ST_MEM_WB,
        S_MEM_WRITE = ST_MEM_WRITE,
        S_EXEC_R    = ST_EXEC_R,
        S_R_WB      = ST_R_WB,
        S_BRANCH    = ST_BRANCH,
        S_JUMP      = ST_JUMP,
        S_ADDI_EXEC = ST_ADDI_EXEC,
        S_ADDI_WB   = ST_ADDI_WB,
        S_ILLEGAL   = ST_ILLEGAL
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU     = 2'b00;
    localparam logic [1:0] PCSRC_ALU_OUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP    = 2'b10;

endpackage

`default_nettype wire

// File: rtl/ctrl_next_state.sv
// ============================================================================
// Module   : ctrl_next_state
// Purpose  : Combinational next-state logic of the multi-cycle control FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_next_state
    import mips_ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_op_code,
    input  logic [5:0] i_op_latched,
    input  logic       i_mem_ready,
    output state_t     o_next_state
);

    always_comb begin
        o_next_state = S_FETCH;
        case (i_state)
            S_FETCH:     o_next_state = i_mem_ready ? S_DECODE : S_FETCH;
            // Live opcode is only trusted here; the latch captures it on this same edge.
            S_DECODE: begin
                case (i_op_code)
                    OP_LW, OP_SW: o_next_state = S_MEM_ADDR;
                    OP_RTYPE:     o_next_state = S_EXEC_R;
                    OP_BEQ:       o_next_state = S_BRANCH;
                    OP_ADDI:      o_next_state = S_ADDI_EXEC;
                    OP_J:         o_next_state = S_JUMP;
                    default:      o_next_state = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR:  o_next_state = (i_op_latched == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  o_next_state = i_mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: o_next_state = i_mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXEC_R:    o_next_state = S_R_WB;
            S_ADDI_EXEC: o_next_state = S_ADDI_WB;
            default:     o_next_state = S_FETCH;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_multiciclo.sv
// ============================================================================
// Module   : control_multiciclo
// Purpose  : Moore control FSM for a multi-cycle MIPS datapath.
//            Define CTRL_MEM_WAIT_EN to let mem_ready stall memory states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_multiciclo
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op_code,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read_enable,
    output logic       mem_write_enable,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op_code,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t     state_q;
    state_t     state_d;
    logic [5:0] opcode_q;
    logic [5:0] opcode_d;
    logic       mem_ready_eff;

`ifdef CTRL_MEM_WAIT_EN
    assign mem_ready_eff = mem_ready;
`else
    assign mem_ready_eff = mem_ready | 1'b1;
`endif

    ctrl_next_state u_next_state (
        .i_state      (state_q),
        .i_op_code    (op_code),
        .i_op_latched (opcode_q),
        .i_mem_ready  (mem_ready_eff),
        .o_next_state (state_d)
    );

    always_comb begin
        opcode_d = opcode_q;
        if (state_q == S_DECODE) begin
            opcode_d = op_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            opcode_q <= 6'd0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    assign state = state_q;

    always_comb begin
        pc_write         = 1'b0;
        pc_write_cond    = 1'b0;
        i_or_d           = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        ir_write         = 1'b0;
        mem_to_reg       = 1'b0;
        reg_dst          = 1'b0;
        reg_write        = 1'b0;
        alu_src_a        = 1'b0;
        alu_src_b        = SRCB_RT;
        alu_op_code      = ALU_ADD;
        pc_source        = PCSRC_ALU;
        instr_done       = 1'b0;
        illegal_op       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read_enable = 1'b1;
                alu_src_b       = SRCB_FOUR;
                ir_write        = mem_ready_eff;
                pc_write        = mem_ready_eff;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_read_enable = 1'b1;
                i_or_d          = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write_enable = 1'b1;
                i_or_d           = 1'b1;
                instr_done       = mem_ready_eff;
            end
            S_EXEC_R: begin
                alu_src_a   = 1'b1;
                alu_op_code = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op_code   = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALU_OUT;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_ILLEGAL: begin
                illegal_op = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
            end
        endcase

        // Strobes are suppressed combinationally so nothing is written while reset is held.
        if (rst) begin
            pc_write         = 1'b0;
            pc_write_cond    = 1'b0;
            ir_write         = 1'b0;
            mem_read_enable  = 1'b0;
            mem_write_enable = 1'b0;
            reg_write        = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_control_multiciclo.sv
// ============================================================================
// Module   : tb_control_multiciclo
// Purpose  : Directed self-checking bench for control_multiciclo; expectations
//            follow CTRL_MEM_WAIT_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_multiciclo;

    logic       clk;
    logic       rst;
    logic [5:0] op_code;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read_enable, mem_write_enable;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op_code;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       instr_done, illegal_op;

    int n_vec  = 0;
    int n_fail = 0;

    // Output vector, msb first:
    // pc_write pc_write_cond i_or_d mem_read mem_write ir_write mem_to_reg reg_dst reg_write alu_src_a | src_b | alu_op | pc_src | done illegal
    logic [18:0] outs;
    assign outs = {pc_write, pc_write_cond, i_or_d, mem_read_enable, mem_write_enable,
                   ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                   alu_src_b, alu_op_code, pc_source, instr_done, illegal_op};

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3,
                           MEM_WB = 4'd4, MEM_WRITE = 4'd5, EXEC_R = 4'd6, R_WB = 4'd7,
                           BRANCH = 4'd8, JUMP = 4'd9, ADDI_EXEC = 4'd10, ADDI_WB = 4'd11,
                           ILLEGAL = 4'd12;

    localparam logic [18:0] E_FETCH      = 19'b1001010000_01_000_00_00;
    localparam logic [18:0] E_FETCH_WAIT = 19'b0001000000_01_000_00_00;
    localparam logic [18:0] E_FETCH_RST  = 19'b0000000000_01_000_00_00;
    localparam logic [18:0] E_DECODE     = 19'b0000000000_11_000_00_00;
    localparam logic [18:0] E_MEM_ADDR   = 19'b0000000001_10_000_00_00;
    localparam logic [18:0] E_MEM_READ   = 19'b0011000000_00_000_00_00;
    localparam logic [18:0] E_MEM_RD_RST = 19'b0010000000_00_000_00_00;
    localparam logic [18:0] E_MEM_WB     = 19'b0000001010_00_000_00_10;
    localparam logic [18:0] E_MEM_WRITE  = 19'b0010100000_00_000_00_10;
    localparam logic [18:0] E_MEM_WR_WT  = 19'b0010100000_00_000_00_00;
    localparam logic [18:0] E_EXEC_R     = 19'b0000000001_00_010_00_00;
    localparam logic [18:0] E_R_WB       = 19'b0000000110_00_000_00_10;
    localparam logic [18:0] E_BRANCH     = 19'b0100000001_00_001_01_10;
    localparam logic [18:0] E_JUMP       = 19'b1000000000_00_000_10_10;
    localparam logic [18:0] E_ADDI_WB    = 19'b0000000010_00_000_00_10;
    localparam logic [18:0] E_ILLEGAL    = 19'b0000000000_00_000_00_11;

    control_multiciclo dut (
        .clk              (clk),
        .rst              (rst),
        .op_code          (op_code),
        .mem_ready        (mem_ready),
        .pc_write         (pc_write),
        .pc_write_cond    (pc_write_cond),
        .i_or_d           (i_or_d),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .ir_write         (ir_write),
        .mem_to_reg       (mem_to_reg),
        .reg_dst          (reg_dst),
        .reg_write        (reg_write),
        .alu_src_a        (alu_src_a),
        .alu_src_b        (alu_src_b),
        .alu_op_code      (alu_op_code),
        .pc_source        (pc_source),
        .state            (state),
        .instr_done       (instr_done),
        .illegal_op       (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checks the current cycle at the falling edge, then advances to just after the next rising edge.
    task automatic step(input string tag, input logic [3:0] es, input logic [18:0] eo);
        @(negedge clk);
        n_vec++;
        assert ({state, outs} === {es, eo})
        else begin
            n_fail++;
            $error("FAIL %s: observed state=%0d outs=%b, expected state=%0d outs=%b",
                   tag, state, outs, es, eo);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        op_code   = 6'b000000;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step("reset_0", FETCH, E_FETCH_RST);
        step("reset_1", FETCH, E_FETCH_RST);
        rst = 1'b0;

        // R-type
        op_code = 6'b000000;
        step("r_fetch",  FETCH,  E_FETCH);
        step("r_decode", DECODE, E_DECODE);
        op_code = 6'b100011;
        step("r_exec",   EXEC_R, E_EXEC_R);
        step("r_wb",     R_WB,   E_R_WB);

        // addi
        op_code = 6'b001000;
        step("addi_fetch",  FETCH,     E_FETCH);
        step("addi_decode", DECODE,    E_DECODE);
        step("addi_exec",   ADDI_EXEC, E_MEM_ADDR);
        step("addi_wb",     ADDI_WB,   E_ADDI_WB);

        // sw then beq
        op_code = 6'b101011;
        step("sw_fetch",  FETCH,     E_FETCH);
        step("sw_decode", DECODE,    E_DECODE);
        op_code = 6'b100011;
        step("sw_addr",   MEM_ADDR,  E_MEM_ADDR);
        step("sw_write",  MEM_WRITE, E_MEM_WRITE);
        op_code = 6'b000100;
        step("beq_fetch",  FETCH,  E_FETCH);
        step("beq_decode", DECODE, E_DECODE);
        step("beq_exec",   BRANCH, E_BRANCH);

        // illegal opcode
        op_code = 6'b111111;
        step("ill_fetch",  FETCH,   E_FETCH);
        step("ill_decode", DECODE,  E_DECODE);
        op_code = 6'b000000;
        step("ill_pulse",  ILLEGAL, E_ILLEGAL);

`ifdef CTRL_MEM_WAIT_EN
        // lw with a FETCH stall, then two MEM_READ stalls
        op_code   = 6'b100011;
        mem_ready = 1'b0;
        step("lw_fetch_wait", FETCH, E_FETCH_WAIT);
        mem_ready = 1'b1;
        step("lw_fetch",  FETCH,    E_FETCH);
        step("lw_decode", DECODE,   E_DECODE);
        op_code = 6'b101011;
        step("lw_addr",   MEM_ADDR, E_MEM_ADDR);
        mem_ready = 1'b0;
        step("lw_read_w0", MEM_READ, E_MEM_READ);
        step("lw_read_w1", MEM_READ, E_MEM_READ);
        mem_ready = 1'b1;
        step("lw_read",   MEM_READ, E_MEM_READ);
        step("lw_wb",     MEM_WB,   E_MEM_WB);

        // sw with one MEM_WRITE stall
        op_code = 6'b101011;
        step("sw2_fetch",  FETCH,    E_FETCH);
        step("sw2_decode", DECODE,   E_DECODE);
        step("sw2_addr",   MEM_ADDR, E_MEM_ADDR);
        mem_ready = 1'b0;
        step("sw2_write_w", MEM_WRITE, E_MEM_WR_WT);
        mem_ready = 1'b1;
        step("sw2_write",  MEM_WRITE, E_MEM_WRITE);
`else
        // mem_ready held low has no effect in this build
        mem_ready = 1'b0;
        op_code   = 6'b100011;
        step("lw_fetch",  FETCH,    E_FETCH);
        step("lw_decode", DECODE,   E_DECODE);
        op_code = 6'b101011;
        step("lw_addr",   MEM_ADDR, E_MEM_ADDR);
        step("lw_read",   MEM_READ, E_MEM_READ);
        step("lw_wb",     MEM_WB,   E_MEM_WB);
        op_code = 6'b000010;
        step("j_fetch",  FETCH,  E_FETCH);
        step("j_decode", DECODE, E_DECODE);
        step("j_exec",   JUMP,   E_JUMP);
        mem_ready = 1'b1;
`endif

        // reset asserted in the middle of a lw
        op_code = 6'b100011;
        step("rlw_fetch",  FETCH,    E_FETCH);
        step("rlw_decode", DECODE,   E_DECODE);
        step("rlw_addr",   MEM_ADDR, E_MEM_ADDR);
        rst = 1'b1;
        step("rlw_read_rst", MEM_READ, E_MEM_RD_RST);
        step("rlw_after",    FETCH,    E_FETCH_RST);
        n_vec++;
        assert (dut.opcode_q === 6'd0)
        else begin
            n_fail++;
            $error("FAIL opcode_latch_reset: observed %b, expected %b", dut.opcode_q, 6'd0);
        end
        rst     = 1'b0;
        op_code = 6'b000010;
        step("post_rst_fetch", FETCH,  E_FETCH);
        step("j2_decode",      DECODE, E_DECODE);
        step("j2_exec",        JUMP,   E_JUMP);
        step("j2_next",        FETCH,  E_FETCH);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire
